mdu_div_seq: RTL

MDU_DIV_SEQ -- requirements
Module: mdu_div_seq

---
 rtl/mdu_div_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mdu_div_seq.sv
// Sequential integer divider: one restoring shift-subtract step per cycle.
// Handles DIV/DIVU/REM/REMU, with divide-by-zero and signed overflow resolved
// at acceptance so that they complete in a single cycle.
module mdu_div_seq #(
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [1:0]            operator_i,
   input  logic [WORD_WIDTH-1:0] operand_a_i,
   input  logic [WORD_WIDTH-1:0] operand_b_i,
   input  logic                  flush_i,
   output logic                  ready_o,
   output logic                  stall_o,
   output logic                  valid_o,
   output logic [WORD_WIDTH-1:0] result_o
);

   localparam int unsigned W  = WORD_WIDTH;
   localparam int unsigned CW = $clog2(WORD_WIDTH) + 1;

   // operator_i[1] selects remainder, operator_i[0] selects unsigned
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        state,      state_nxt;
   logic [CW-1:0] count,      count_nxt;
   logic [W:0]    prem,       prem_nxt;
   logic [W-1:0]  quo,        quo_nxt;
   logic [W-1:0]  dvsr,       dvsr_nxt;
   logic [1:0]    op,         op_nxt;
   logic          sign_q,     sign_q_nxt;
   logic          sign_r,     sign_r_nxt;

   logic          a_neg, b_neg, div_zero, ovf;
   logic [W-1:0]  a_mag, b_mag;
   logic [W:0]    shifted, diff;
   logic [W-1:0]  sel, res_val;
   logic          res_neg;

   // Operand conditioning and one restoring iteration
   always_comb begin
      a_neg    = ~operator_i[0] & operand_a_i[W-1];
      b_neg    = ~operator_i[0] & operand_b_i[W-1];
      a_mag    = a_neg ? (~operand_a_i + W'(1)) : operand_a_i;
      b_mag    = b_neg ? (~operand_b_i + W'(1)) : operand_b_i;
      div_zero = (operand_b_i == '0);
      ovf      = ~operator_i[0]
                 & (operand_a_i == {1'b1, {(W-1){1'b0}}})
                 & (operand_b_i == '1);
      shifted  = {prem[W-1:0], quo[W-1]};
      diff     = shifted - {1'b0, dvsr};
      sel      = op[1] ? prem[W-1:0] : quo;
      res_neg  = op[1] ? sign_r : sign_q;
      res_val  = res_neg ? (~sel + W'(1)) : sel;
   end

   // Next-state, datapath update and output decode
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      prem_nxt   = prem;
      quo_nxt    = quo;
      dvsr_nxt   = dvsr;
      op_nxt     = op;
      sign_q_nxt = sign_q;
      sign_r_nxt = sign_r;
      ready_o    = 1'b0;
      stall_o    = 1'b0;
      valid_o    = 1'b0;
      result_o   = '0;

      case (state)
         IDLE: begin
            ready_o = 1'b1;
            stall_o = start_i & ~flush_i;
            if (start_i && !flush_i) begin
               op_nxt = operator_i;
               if (div_zero) begin
                  state_nxt  = DONE;
                  quo_nxt    = '1;
                  prem_nxt   = {1'b0, operand_a_i};
                  sign_q_nxt = 1'b0;
                  sign_r_nxt = 1'b0;
               end else if (ovf) begin
                  state_nxt  = DONE;
                  quo_nxt    = {1'b1, {(W-1){1'b0}}};
                  prem_nxt   = '0;
                  sign_q_nxt = 1'b0;
                  sign_r_nxt = 1'b0;
               end else begin
                  state_nxt  = DIVIDE;
                  count_nxt  = CW'(W);
                  prem_nxt   = '0;
                  quo_nxt    = a_mag;
                  dvsr_nxt   = b_mag;
                  sign_q_nxt = a_neg ^ b_neg;
                  sign_r_nxt = a_neg;
               end
            end
         end
         DIVIDE: begin
            stall_o   = ~flush_i;
            count_nxt = count - CW'(1);
            if (!diff[W]) begin
               prem_nxt = diff;
               quo_nxt  = {quo[W-2:0], 1'b1};
            end else begin
               prem_nxt = shifted;
               quo_nxt  = {quo[W-2:0], 1'b0};
            end
            if (count == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            valid_o   = ~flush_i;
            result_o  = res_val;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (flush_i) begin
         state_nxt = IDLE;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         prem   <= '0;
         quo    <= '0;
         dvsr   <= '0;
         op     <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         prem   <= prem_nxt;
         quo    <= quo_nxt;
         dvsr   <= dvsr_nxt;
         op     <= op_nxt;
         sign_q <= sign_q_nxt;
         sign_r <= sign_r_nxt;
      end
   end

endmodule
